// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: result-bus / common-data-bus bundle around cdb_arbiter.
//   result0..2 : execution-unit result packets {valid, reg_write, data, tag}
//   cdb0, cdb1 : registered CDB broadcast packets (same layout)
//   stall      : per-source hold-off back to issue
//   overflow   : sticky "packet dropped at a full FIFO" flag
// Modport slave is the arbiter side; master is the execution/issue side.
interface cdb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 6
);
  localparam int unsigned RES_W = 2 + DATA_W + TAG_W;

  logic [RES_W-1:0] result0;
  logic [RES_W-1:0] result1;
  logic [RES_W-1:0] result2;
  logic [RES_W-1:0] cdb0;
  logic [RES_W-1:0] cdb1;
  logic [2:0]       stall;
  logic             overflow;

  modport slave (
    input  result0, result1, result2,
    output cdb0, cdb1, stall, overflow
  );

  modport master (
    output result0, result1, result2,
    input  cdb0, cdb1, stall, overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: captures ALU0/ALU1/MEM result packets into per-source FIFOs
// and drains up to two per cycle onto the two CDB ports, round-robin.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   flush : synchronous flush; empties all FIFOs and clears the CDB
//   bus   : cdb_arbiter_if.slave (result0..2 in; cdb0/cdb1/stall/overflow out)
module cdb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned RES_W = 2 + DATA_W + TAG_W;
  localparam int unsigned ENT_W = RES_W - 1;         // stored without valid bit
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned NSRC  = 3;

  logic [RES_W-1:0] res     [NSRC];
  logic [ENT_W-1:0] mem     [NSRC][DEPTH];
  logic [PW-1:0]    rd_ptr  [NSRC];
  logic [PW-1:0]    wr_ptr  [NSRC];
  logic [CW-1:0]    count   [NSRC];
  logic [1:0]       rr;
  logic [1:0]       rr_next;
  logic [1:0]       idx;
  logic [1:0]       g0;
  logic [1:0]       g1;
  logic             g0_vld;
  logic             g1_vld;
  logic [NSRC-1:0]  pop;
  logic [NSRC-1:0]  push;
  logic [NSRC-1:0]  drop;
  logic [NSRC-1:0]  stall_w;
  logic [RES_W-1:0] cdb0_d;
  logic [RES_W-1:0] cdb1_d;
  logic [RES_W-1:0] cdb0_q;
  logic [RES_W-1:0] cdb1_q;
  logic             overflow_q;

  function automatic logic [1:0] wrap3(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  always_comb begin
    res[0] = bus.result0;
    res[1] = bus.result1;
    res[2] = bus.result2;
  end

  // Grant: walk sources starting at rr; first two non-empty FIFOs win.
  // Eligibility uses registered counts only, so same-cycle pushes never bypass.
  always_comb begin
    g0      = '0;
    g1      = '0;
    g0_vld  = 1'b0;
    g1_vld  = 1'b0;
    idx     = '0;
    pop     = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      idx = wrap3(rr, 2'(k));
      if (count[idx] != '0) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0     = idx;
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1     = idx;
        end
      end
    end
    if (g0_vld) pop[g0] = 1'b1;
    if (g1_vld) pop[g1] = 1'b1;

    if (g1_vld)      rr_next = wrap3(g1, 2'd1);
    else if (g0_vld) rr_next = wrap3(g0, 2'd1);
    else             rr_next = rr;

    cdb0_d = g0_vld ? {1'b1, mem[g0][rd_ptr[g0]]} : '0;
    cdb1_d = g1_vld ? {1'b1, mem[g1][rd_ptr[g1]]} : '0;
  end

  // A full FIFO still accepts when it is popped in the same cycle.
  always_comb begin
    push    = '0;
    drop    = '0;
    stall_w = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      push[i]    = res[i][RES_W-1] && !flush && ((count[i] != CW'(DEPTH)) || pop[i]);
      drop[i]    = res[i][RES_W-1] && !flush && (count[i] == CW'(DEPTH)) && !pop[i];
      stall_w[i] = (count[i] >= CW'(DEPTH - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr         <= '0;
      cdb0_q     <= '0;
      cdb1_q     <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      cdb0_q <= '0;
      cdb1_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
      rr         <= rr_next;
      cdb0_q     <= cdb0_d;
      cdb1_q     <= cdb1_d;
      overflow_q <= overflow_q | (|drop);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= res[i][ENT_W-1:0];
    end
  end

  assign bus.cdb0     = cdb0_q;
  assign bus.cdb1     = cdb1_q;
  assign bus.stall    = stall_w;
  assign bus.overflow = overflow_q;
endmodule
